// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding-request fetcher with branch redirect and drain.
// Optional fetch_count performance counter is enabled by defining IFU_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      r_state,     w_state;
  logic        r_idle_done, w_idle_done;
  logic [31:0] r_next_pc,   w_next_pc;
  logic [31:0] r_target,    w_target;
  logic [31:0] r_if_instr,  w_if_instr;
  logic [31:0] r_if_pc,     w_if_pc;
  logic [31:0] w_target_aligned;

  assign w_target_aligned = {branch_target[31:2], 2'b00};

  // NOTE: every state register is updated with <= so all flops sample the
  // same pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idle_done <= 1'b0;
      r_next_pc   <= RESET_PC_ALIGNED;
      r_target    <= 32'h0000_0000;
      r_if_instr  <= NOP_INSTR;
      r_if_pc     <= 32'h0000_0000;
    end else begin
      r_state     <= w_state;
      r_idle_done <= w_idle_done;
      r_next_pc   <= w_next_pc;
      r_target    <= w_target;
      r_if_instr  <= w_if_instr;
      r_if_pc     <= w_if_pc;
    end
  end

  // NOTE: each w_ signal gets its hold value first, so no path through the
  // case statement can leave it unassigned and infer a latch.
  always_comb begin
    w_state     = r_state;
    w_idle_done = r_idle_done;
    w_next_pc   = r_next_pc;
    w_target    = r_target;
    w_if_instr  = r_if_instr;
    w_if_pc     = r_if_pc;
    unique case (r_state)
      IDLE: begin
        // First edge after reset only arms the flag; FETCH starts on the second.
        w_idle_done = 1'b1;
        if (branch_taken) w_next_pc = w_target_aligned;
        if (r_idle_done)  w_state   = FETCH;
      end
      FETCH: begin
        if (branch_taken) begin
          if (imem_ack) begin
            w_next_pc = w_target_aligned;
          end else begin
            w_target = w_target_aligned;
            w_state  = DRAIN;
          end
        end else if (imem_ack) begin
          w_if_instr = imem_rdata;
          w_if_pc    = r_next_pc;
          w_next_pc  = r_next_pc + 32'd4;
          w_state    = VALID;
        end
      end
      VALID: begin
        if (branch_taken) begin
          w_next_pc = w_target_aligned;
          w_state   = FETCH;
        end else if (id_ready) begin
          w_state = FETCH;
        end
      end
      DRAIN: begin
        // The old request is still in flight; its data is dropped on arrival.
        if (branch_taken) begin
          if (imem_ack) begin
            w_next_pc = w_target_aligned;
            w_state   = FETCH;
          end else begin
            w_target = w_target_aligned;
          end
        end else if (imem_ack) begin
          w_next_pc = r_target;
          w_state   = FETCH;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign imem_req  = (r_state == FETCH) || (r_state == DRAIN);
  assign imem_addr = imem_req ? r_next_pc : 32'h0000_0000;
  assign if_valid  = (r_state == VALID);
  assign if_instr  = r_if_instr;
  assign if_pc     = r_if_pc;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_fetch_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= 32'h0000_0000;
    end else if (if_valid && id_ready && !branch_taken) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
`endif

endmodule
